// File: rtl/ps2_poly_keymap_if.sv
// Byte stream bus from the PS/2 receiver into the keymap decoder.
// The receiver drives it through the master modport and the decoder reads it
// through the slave modport.
interface ps2_byte_if;
    logic       byte_valid;
    logic [7:0] byte_data;

    modport master (output byte_valid, output byte_data);
    modport slave  (input  byte_valid, input  byte_data);
endinterface

// File: rtl/ps2_poly_keymap.sv
// ps2_poly_keymap: polyphonic PS/2 scancode to synth control decoder.
// Parses make / break (F0) / extended (E0) sequences, allocates note keys to
// NUM_VOICES gated voice slots and emits one-cycle octave/ADSR control pulses.
// Optional feature macro: OCTAVE_TRACK_EN adds an internal saturating octave
// register and the octave output port.
module ps2_poly_keymap #(
    parameter int NUM_VOICES  = 4,
    parameter int NOTE_W      = 4
`ifdef OCTAVE_TRACK_EN
    ,
    parameter int OCT_W       = 3,
    parameter int OCT_DEFAULT = 4
`endif
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    ps2_byte_if.slave                    byte_in,
    output logic [NUM_VOICES*NOTE_W-1:0] voice_note,
    output logic [NUM_VOICES-1:0]        voice_gate,
    output logic                         note_on,
    output logic                         note_off,
    output logic [2:0]                   event_voice,
    output logic                         voice_overflow,
    output logic                         octave_minus_minus,
    output logic                         octave_plus_plus,
    output logic                         ADSR_minus_minus,
    output logic                         ADSR_plus_plus,
    output logic [2:0]                   ADSR_selector
`ifdef OCTAVE_TRACK_EN
    ,
    output logic [OCT_W-1:0]             octave
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

    state_t             state, state_nxt;
    logic               do_make, do_break;
    logic               note_ok, ctl_ok;
    logic [NOTE_W-1:0]  note_code;
    logic [3:0]         ctl_idx;
    logic               hit, free_found;
    logic [2:0]         hit_idx, free_idx;
    logic               alloc, release_v;
    logic [8:0]         ctl_held;

    // Scancode to note number; MSB of the result flags a mapped key.
    function automatic logic [NOTE_W:0] map_note(input logic [7:0] code);
        logic [3:0] n;
        logic       v;
        v = 1'b1;
        n = 4'd0;
        case (code)
            8'h1C: n = 4'd0;
            8'h1D: n = 4'd1;
            8'h1B: n = 4'd2;
            8'h24: n = 4'd3;
            8'h23: n = 4'd4;
            8'h2B: n = 4'd5;
            8'h2C: n = 4'd6;
            8'h34: n = 4'd7;
            8'h35: n = 4'd8;
            8'h33: n = 4'd9;
            8'h3C: n = 4'd10;
            8'h3B: n = 4'd11;
            default: v = 1'b0;
        endcase
        return {v, NOTE_W'(n)};
    endfunction

    // Control keys: Z,X,C,V -> 0..3, number keys 1..5 -> 4..8.
    function automatic logic [4:0] map_ctl(input logic [7:0] code);
        logic [3:0] k;
        logic       v;
        v = 1'b1;
        k = 4'd0;
        case (code)
            8'h1A: k = 4'd0;
            8'h22: k = 4'd1;
            8'h21: k = 4'd2;
            8'h2A: k = 4'd3;
            8'h16: k = 4'd4;
            8'h1E: k = 4'd5;
            8'h26: k = 4'd6;
            8'h25: k = 4'd7;
            8'h2E: k = 4'd8;
            default: v = 1'b0;
        endcase
        return {v, k};
    endfunction

`ifdef OCTAVE_TRACK_EN
    // Saturating one-step octave change.
    function automatic logic [OCT_W-1:0] oct_step(input logic [OCT_W-1:0] cur,
                                                  input logic up);
        if (up)
            return (cur == {OCT_W{1'b1}}) ? cur : cur + 1'b1;
        else
            return (cur == '0) ? cur : cur - 1'b1;
    endfunction
`endif

    // Parser state register; reset drops any partial prefix.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) state <= S_IDLE;
        else         state <= state_nxt;
    end

    // Parser next state and make/break decode for the current byte.
    always_comb begin
        state_nxt = state;
        do_make   = 1'b0;
        do_break  = 1'b0;
        if (byte_in.byte_valid) begin
            case (state)
                S_IDLE: begin
                    if (byte_in.byte_data == 8'hE0)      state_nxt = S_EXT;
                    else if (byte_in.byte_data == 8'hF0) state_nxt = S_BRK;
                    else                                 do_make   = 1'b1;
                end
                S_BRK: begin
                    do_break  = 1'b1;
                    state_nxt = S_IDLE;
                end
                S_EXT:     state_nxt = (byte_in.byte_data == 8'hF0) ? S_EXT_BRK : S_IDLE;
                S_EXT_BRK: state_nxt = S_IDLE;
                default:   state_nxt = S_IDLE;
            endcase
        end
    end

    // Key lookup and voice slot search: held-key hit and lowest free slot.
    always_comb begin
        {note_ok, note_code} = map_note(byte_in.byte_data);
        {ctl_ok, ctl_idx}    = map_ctl(byte_in.byte_data);
        hit        = 1'b0;
        hit_idx    = 3'd0;
        free_found = 1'b0;
        free_idx   = 3'd0;
        for (int i = NUM_VOICES - 1; i >= 0; i--) begin
            if (voice_gate[i] && voice_note[i*NOTE_W +: NOTE_W] == note_code) begin
                hit     = 1'b1;
                hit_idx = 3'(i);
            end
            if (!voice_gate[i]) begin
                free_found = 1'b1;
                free_idx   = 3'(i);
            end
        end
        alloc     = do_make  && note_ok && !hit && free_found;
        release_v = do_break && note_ok && hit;
    end

    // Voice slots and note event pulses.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            voice_note     <= '0;
            voice_gate     <= '0;
            note_on        <= 1'b0;
            note_off       <= 1'b0;
            event_voice    <= 3'd0;
            voice_overflow <= 1'b0;
        end else begin
            note_on        <= alloc;
            note_off       <= release_v;
            voice_overflow <= do_make && note_ok && !hit && !free_found;
            if (alloc)     event_voice <= free_idx;
            if (release_v) event_voice <= hit_idx;
            for (int i = 0; i < NUM_VOICES; i++) begin
                if (alloc && free_idx == 3'(i)) begin
                    voice_note[i*NOTE_W +: NOTE_W] <= note_code;
                    voice_gate[i]                  <= 1'b1;
                end
                if (release_v && hit_idx == 3'(i))
                    voice_gate[i] <= 1'b0;
            end
        end
    end

    // Control keys: act once per press, repeats suppressed by the held mask.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            ctl_held           <= '0;
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            ADSR_minus_minus   <= 1'b0;
            ADSR_plus_plus     <= 1'b0;
            ADSR_selector      <= 3'd0;
`ifdef OCTAVE_TRACK_EN
            octave             <= OCT_W'(OCT_DEFAULT);
`endif
        end else begin
            octave_minus_minus <= 1'b0;
            octave_plus_plus   <= 1'b0;
            ADSR_minus_minus   <= 1'b0;
            ADSR_plus_plus     <= 1'b0;
            if (do_make && ctl_ok && !ctl_held[ctl_idx]) begin
                ctl_held[ctl_idx] <= 1'b1;
                case (ctl_idx)
                    4'd0: begin
                        octave_minus_minus <= 1'b1;
`ifdef OCTAVE_TRACK_EN
                        octave <= oct_step(octave, 1'b0);
`endif
                    end
                    4'd1: begin
                        octave_plus_plus <= 1'b1;
`ifdef OCTAVE_TRACK_EN
                        octave <= oct_step(octave, 1'b1);
`endif
                    end
                    4'd2:    ADSR_minus_minus <= 1'b1;
                    4'd3:    ADSR_plus_plus   <= 1'b1;
                    default: ADSR_selector    <= 3'(ctl_idx - 4'd4);
                endcase
            end
            if (do_break && ctl_ok)
                ctl_held[ctl_idx] <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_poly_keymap.sv
// Testbench for ps2_poly_keymap: scoreboard of expected pulse events plus
// direct level checks of voice slots, gates, selector and octave.
module tb_ps2_poly_keymap;
    localparam int NV = 4;
    localparam int NW = 4;

    localparam int K_ON  = 1;
    localparam int K_OFF = 2;
    localparam int K_OVF = 3;
    localparam int K_OMM = 4;
    localparam int K_OPP = 5;
    localparam int K_AMM = 6;
    localparam int K_APP = 7;

    logic             CLOCK_50 = 1'b0;
    logic             resetn   = 1'b0;
    logic [NV*NW-1:0] voice_note;
    logic [NV-1:0]    voice_gate;
    logic             note_on, note_off, voice_overflow;
    logic [2:0]       event_voice;
    logic             octave_minus_minus, octave_plus_plus;
    logic             ADSR_minus_minus, ADSR_plus_plus;
    logic [2:0]       ADSR_selector;
`ifdef OCTAVE_TRACK_EN
    logic [2:0]       octave;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int kind;
        int voice;
    } ev_t;
    ev_t sb_q[$];

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_byte_if bi ();

    ps2_poly_keymap #(
        .NUM_VOICES (NV),
        .NOTE_W     (NW)
`ifdef OCTAVE_TRACK_EN
        ,
        .OCT_W      (3),
        .OCT_DEFAULT(4)
`endif
    ) dut (
        .CLOCK_50          (CLOCK_50),
        .resetn            (resetn),
        .byte_in           (bi),
        .voice_note        (voice_note),
        .voice_gate        (voice_gate),
        .note_on           (note_on),
        .note_off          (note_off),
        .event_voice       (event_voice),
        .voice_overflow    (voice_overflow),
        .octave_minus_minus(octave_minus_minus),
        .octave_plus_plus  (octave_plus_plus),
        .ADSR_minus_minus  (ADSR_minus_minus),
        .ADSR_plus_plus    (ADSR_plus_plus),
        .ADSR_selector     (ADSR_selector)
`ifdef OCTAVE_TRACK_EN
        ,
        .octave            (octave)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic expect_ev(input int kind, input int voice);
        ev_t e;
        e.kind  = kind;
        e.voice = voice;
        sb_q.push_back(e);
    endtask

    task automatic got_ev(input int kind, input int voice);
        ev_t e;
        if (sb_q.size() == 0) begin
            check_eq("sb_unexpected", kind, 0);
        end else begin
            e = sb_q.pop_front();
            check_eq("sb_kind", kind, e.kind);
            if (kind == K_ON || kind == K_OFF)
                check_eq("sb_voice", voice, e.voice);
        end
    endtask

    // Pulse monitor: every observed pulse must match the front of the scoreboard.
    always @(negedge CLOCK_50) begin
        if (resetn) begin
            if (note_on)            got_ev(K_ON,  int'(event_voice));
            if (note_off)           got_ev(K_OFF, int'(event_voice));
            if (voice_overflow)     got_ev(K_OVF, 0);
            if (octave_minus_minus) got_ev(K_OMM, 0);
            if (octave_plus_plus)   got_ev(K_OPP, 0);
            if (ADSR_minus_minus)   got_ev(K_AMM, 0);
            if (ADSR_plus_plus)     got_ev(K_APP, 0);
        end
    end

    function automatic logic [NW-1:0] slot(input int i);
        return voice_note[i*NW +: NW];
    endfunction

    // Presents one byte for one cycle; called from posedge+1, returns at posedge+1.
    task automatic send(input logic [7:0] b);
        bi.byte_valid = 1'b1;
        bi.byte_data  = b;
        @(posedge CLOCK_50);
        #1;
        bi.byte_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bi.byte_valid = 1'b0;
        bi.byte_data  = 8'h00;
        resetn        = 1'b0;
        idle(3);
        check_eq("rst_gate", voice_gate, 0);
        check_eq("rst_note", voice_note, 0);
        check_eq("rst_sel", ADSR_selector, 0);
        check_eq("rst_pulses", {note_on, note_off, voice_overflow, octave_minus_minus,
                                octave_plus_plus, ADSR_minus_minus, ADSR_plus_plus}, 0);
`ifdef OCTAVE_TRACK_EN
        check_eq("rst_oct", octave, 4);
`endif
        resetn = 1'b1;
        idle(2);

        // single note make and break
        expect_ev(K_ON, 0);
        send(8'h1C);
        check_eq("mk_slot0", slot(0), 0);
        check_eq("mk_gate", voice_gate, 4'b0001);
        expect_ev(K_OFF, 0);
        send(8'hF0); send(8'h1C);
        check_eq("brk_gate", voice_gate, 4'b0000);
        idle(2);

        // typematic repeat
        expect_ev(K_ON, 0);
        send(8'h1C); send(8'h1C); send(8'h1C);
        check_eq("typ_gate", voice_gate, 4'b0001);
        expect_ev(K_OFF, 0);
        send(8'hF0); send(8'h1C);
        idle(2);

        // allocation and overflow
        expect_ev(K_ON, 0); expect_ev(K_ON, 1); expect_ev(K_ON, 2); expect_ev(K_ON, 3);
        expect_ev(K_OVF, 0);
        send(8'h1C); send(8'h1B); send(8'h23); send(8'h2B); send(8'h34);
        check_eq("al_slot0", slot(0), 0);
        check_eq("al_slot1", slot(1), 2);
        check_eq("al_slot2", slot(2), 4);
        check_eq("al_slot3", slot(3), 5);
        check_eq("al_gate", voice_gate, 4'b1111);
        expect_ev(K_OFF, 1);
        send(8'hF0); send(8'h1B);
        check_eq("fr_gate", voice_gate, 4'b1101);
        check_eq("fr_note_kept", slot(1), 2);
        expect_ev(K_ON, 1);
        send(8'h34);
        check_eq("re_slot1", slot(1), 7);
        check_eq("re_gate", voice_gate, 4'b1111);
        expect_ev(K_OFF, 0); expect_ev(K_OFF, 2); expect_ev(K_OFF, 3); expect_ev(K_OFF, 1);
        send(8'hF0); send(8'h1C); send(8'hF0); send(8'h23);
        send(8'hF0); send(8'h2B); send(8'hF0); send(8'h34);
        check_eq("rel_all_gate", voice_gate, 4'b0000);
        idle(2);

        // extended sequences never act
        send(8'hE0); send(8'h1C); send(8'hE0); send(8'hF0); send(8'h1C);
        idle(1);
        check_eq("ext_gate", voice_gate, 4'b0000);
        expect_ev(K_ON, 0);
        send(8'h1D);
        check_eq("ext_after_slot0", slot(0), 1);
        check_eq("ext_after_gate", voice_gate, 4'b0001);
        expect_ev(K_OFF, 0);
        send(8'hF0); send(8'h1D);
        idle(2);

        // control keys
        send(8'h26);
        check_eq("sel_2", ADSR_selector, 2);
        expect_ev(K_OPP, 0);
        send(8'h22); send(8'h22);
        send(8'hF0); send(8'h22);
        expect_ev(K_OPP, 0);
        send(8'h22);
        check_eq("sel_hold", ADSR_selector, 2);
        expect_ev(K_OMM, 0);
        send(8'h1A);
        expect_ev(K_AMM, 0);
        send(8'h21);
        expect_ev(K_APP, 0);
        send(8'h2A);
        send(8'h55);
        idle(1);
        check_eq("unmapped_gate", voice_gate, 4'b0000);
        send(8'h2E);
        check_eq("sel_4", ADSR_selector, 4);
`ifdef OCTAVE_TRACK_EN
        check_eq("oct_5", octave, 5);
`endif
        send(8'hF0); send(8'h22); send(8'hF0); send(8'h1A);
        idle(2);

        // octave up to saturation
        for (int i = 0; i < 8; i++) begin
            expect_ev(K_OPP, 0);
            send(8'h22);
            send(8'hF0); send(8'h22);
        end
        idle(2);
`ifdef OCTAVE_TRACK_EN
        check_eq("oct_sat", octave, 7);
`endif

        // asynchronous reset in the middle of a break sequence
        expect_ev(K_ON, 0);
        send(8'h1C);
        send(8'hF0);
        idle(1);
        check_eq("pre_rst_gate", voice_gate, 4'b0001);
        #2;
        resetn = 1'b0;
        #1;
        check_eq("async_rst_gate", voice_gate, 4'b0000);
`ifdef OCTAVE_TRACK_EN
        check_eq("async_rst_oct", octave, 4);
`endif
        idle(2);
        resetn = 1'b1;
        idle(1);
        expect_ev(K_ON, 0);
        send(8'h1C);
        check_eq("post_rst_gate", voice_gate, 4'b0001);
        expect_ev(K_OPP, 0);
        send(8'h22);
        expect_ev(K_OFF, 0);
        send(8'hF0); send(8'h1C);
        idle(3);

        check_eq("sb_drain", sb_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
